// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding,
// owner IDs and the byte-strobe width.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   localparam int STRB_W = 4;

endpackage

// File: rtl/mem_arbiter_sel.sv
// Winner selection between the inst and data requesters.
// ARB_RR_EN selects round-robin; otherwise data has fixed priority over inst.
module arb_sel
   import mem_arbiter_pkg::*;
(
   input  logic inst_req,
   input  logic data_req,
   input  logic last_grant,
   output logic grant
);

`ifdef ARB_RR_EN
   // On a tie, the requester that did not win last time goes first.
   always_comb begin
      grant = OWN_DATA;
      if (inst_req && data_req) begin
         grant = (last_grant == OWN_DATA) ? OWN_INST : OWN_DATA;
      end else if (inst_req) begin
         grant = OWN_INST;
      end
   end
`else
   logic unused_last;
   assign unused_last = last_grant;

   always_comb begin
      grant = (data_req || !inst_req) ? OWN_DATA : OWN_INST;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an inst (read-only) and a data requester onto one memory port,
// one transaction outstanding at a time. ARB_RR_EN enables round-robin.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,

   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [STRB_W-1:0] data_wstrb,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,

   output logic              mem_req,
   output logic              mem_wr,
   output logic [STRB_W-1:0] mem_wstrb,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic [1:0]        dbg_state
);

   // Handshake: a requester holds xxx_req until xxx_addr_ok is seen high in the
   // same cycle; mem_req is held with stable fields until mem_addr_ok; each
   // data_ok is a single-cycle pulse carrying rdata combinationally.

   state_t              state_q, state_d;
   logic                grant_fire;
   logic                sel;
   logic                last_grant;
   logic                owner_q;
   logic                wr_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                done;

   arb_sel u_arb_sel (
      .inst_req   (inst_req),
      .data_req   (data_req),
      .last_grant (last_grant),
      .grant      (sel)
   );

`ifdef ARB_RR_EN
   logic last_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_q <= OWN_INST;
      end else if (grant_fire) begin
         last_q <= sel;
      end
   end

   assign last_grant = last_q;
`else
   assign last_grant = OWN_INST;
`endif

   always_comb begin
      state_d    = state_q;
      grant_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (inst_req || data_req) begin
               grant_fire = 1'b1;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (mem_addr_ok) state_d = WAIT;
         end
         WAIT: begin
            if (mem_data_ok) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Reads never carry byte strobes, whichever port they came from.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         owner_q <= OWN_INST;
         wr_q    <= 1'b0;
         wstrb_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (grant_fire) begin
         owner_q <= sel;
         if (sel == OWN_DATA) begin
            wr_q    <= data_wr;
            wstrb_q <= data_wr ? data_wstrb : '0;
            addr_q  <= data_addr;
            wdata_q <= data_wdata;
         end else begin
            wr_q    <= 1'b0;
            wstrb_q <= '0;
            addr_q  <= inst_addr;
            wdata_q <= '0;
         end
      end
   end

   assign mem_req   = (state_q == ISSUE);
   assign mem_wr    = wr_q;
   assign mem_wstrb = wstrb_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   // addr_ok is combinational from req, so it is masked while reset is held.
   assign inst_addr_ok = resetn && grant_fire && (sel == OWN_INST);
   assign data_addr_ok = resetn && grant_fire && (sel == OWN_DATA);

   assign done         = (state_q == WAIT) && mem_data_ok;
   assign inst_data_ok = done && (owner_q == OWN_INST);
   assign data_data_ok = done && (owner_q == OWN_DATA);
   assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
   assign data_rdata   = data_data_ok ? mem_rdata : '0;

   assign dbg_state = state_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of all ports.
REQ-002 SHALL have parameter DATA_W, default 32: data width of all ports; strobe width is DATA_W/8.
REQ-003 SHALL have port clk  in  1: the single clock, rising edge.
REQ-004 SHALL have port resetn  in  1: reset, asynchronous assertion, active-low.
REQ-005 SHALL have inst requester ports: inst_req in 1; inst_addr in ADDR_W; inst_addr_ok out 1; inst_data_ok out 1; inst_rdata out DATA_W. This requester is read-only.
REQ-006 SHALL have data requester ports: data_req in 1; data_wr in 1 (1 = write); data_wstrb in 4; data_addr in ADDR_W; data_wdata in DATA_W; data_addr_ok out 1; data_data_ok out 1; data_rdata out DATA_W.
REQ-007 SHALL have memory ports: mem_req out 1; mem_wr out 1; mem_wstrb out 4; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_addr_ok in 1; mem_data_ok in 1; mem_rdata in DATA_W.

Function
REQ-008 SHALL implement a three-state FSM: IDLE, ISSUE, WAIT. At most one memory transaction is outstanding.
REQ-009 In IDLE, with any xxx_req high, SHALL select one winner, pulse its xxx_addr_ok in that same cycle, latch its wr/wstrb/addr/wdata and owner ID, and go to ISSUE. The inst request latches as wr=0, wstrb=0.
REQ-010 In ISSUE, SHALL hold mem_req=1 with the latched fields stable; on mem_addr_ok=1 SHALL go to WAIT, with mem_req low from the next cycle.
REQ-011 In WAIT, on mem_data_ok=1 SHALL assert the owner's xxx_data_ok for that cycle only, with xxx_rdata=mem_rdata (combinational), then go to IDLE.
REQ-012 The minimum latency SHALL be: request accepted in cycle 0, mem_req in cycle 1, and requester data_ok in cycle 2, given mem_addr_ok in cycle 1 and mem_data_ok in cycle 2.
REQ-013 SHALL NOT accept a new request outside IDLE; addr_ok stays 0 in ISSUE and WAIT, and requesters hold their req.
REQ-014 A read SHALL drive mem_wstrb=0. A write with wstrb=0 SHALL still be issued and completed.
REQ-015 SHALL ignore mem_data_ok in IDLE and ISSUE, and SHALL ignore mem_addr_ok in IDLE and WAIT.
REQ-016 The non-owner's data_ok SHALL never assert; both data_ok outputs SHALL never be high together.
REQ-017 The rdata of a non-asserted data_ok SHALL be don't-care; the bench compares rdata only when data_ok=1.
REQ-018 Back-to-back: after WAIT completes, the next grant SHALL occur in the following IDLE cycle, giving one bubble cycle between transactions.

Reset
REQ-019 resetn=0 SHALL force IDLE immediately, asynchronously, including mid-ISSUE or mid-WAIT; the outstanding transaction is dropped.
REQ-020 During reset, all outputs SHALL read 0: mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, both addr_ok and both data_ok.
REQ-021 The round-robin pointer SHALL reset to "inst last granted".
REQ-022 The first cycle after resetn rises SHALL be an IDLE cycle that may grant.

Configuration
REQ-023 Macro ARB_RR_EN defined: simultaneous requests in IDLE SHALL be granted round-robin, choosing the requester not granted last. With a single requester, that requester wins and the pointer updates.
REQ-024 Macro ARB_RR_EN undefined: simultaneous requests SHALL use fixed priority, data over inst, and SHALL have no pointer register.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2), the owner ID constants (OWN_INST=0, OWN_DATA=1) and the strobe-width constant.
REQ-026 The winner-selection logic SHALL be one sub-module, arb_sel: inputs are the two reqs and the last-grant bit; output is the grant owner ID.
REQ-027 The FSM, latches and response routing SHALL stay in mem_arbiter.

Verification
REQ-028 Single inst read 0x1c000000, mem_addr_ok in cycle 1, mem_data_ok in cycle 2 with rdata 0x02800421 -> inst_addr_ok in cycle 0; mem_req=1, mem_wr=0, mem_addr=0x1c000000 in cycle 1; inst_data_ok=1, inst_rdata=0x02800421 in cycle 2.
REQ-029 Data write, addr 0x00001000, wdata 0xdeadbeef, wstrb 4'hf, mem_addr_ok delayed 3 cycles -> mem_req and fields held stable 4 cycles; data_data_ok pulses once only when mem_data_ok arrives.
REQ-030 Both requesting every cycle for 4 transactions -> with ARB_RR_EN the grant order is data, inst, data, inst; without it, all 4 go to data while inst_addr_ok stays 0.
REQ-031 resetn=0 during WAIT -> all outputs 0 at once; a late mem_data_ok after release produces no data_ok; the next request then completes normally.
REQ-032 Spurious mem_data_ok in IDLE, and mem_addr_ok in WAIT -> no data_ok and no state change; a read with wr=0 always drives mem_wstrb=0.
